// File: rtl/alu_if.sv
// Handshake and data bus for multicycle_alu: request fields driven by the
// master, status and registered results driven by the ALU (slave side).
interface alu_if;
  logic        start;
  logic [3:0]  alu_op;
  logic [31:0] alu_in_1;
  logic [31:0] alu_in_2;
  logic        busy;
  logic        done;
  logic [31:0] alu_result;
  logic        alu_bcond;

  modport master (
    output start, alu_op, alu_in_1, alu_in_2,
    input  busy, done, alu_result, alu_bcond
  );

  modport slave (
    input  start, alu_op, alu_in_1, alu_in_2,
    output busy, done, alu_result, alu_bcond
  );
endinterface

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU with iterative 1-bit-per-cycle shifts by default.
// Define FAST_SHIFT_EN to replace the iterative shifter with a barrel shifter.
module multicycle_alu (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);
  localparam logic [3:0] FUNC_ADD  = 4'd1;
  localparam logic [3:0] FUNC_SUB  = 4'd2;
  localparam logic [3:0] FUNC_AND  = 4'd3;
  localparam logic [3:0] FUNC_OR   = 4'd4;
  localparam logic [3:0] FUNC_XOR  = 4'd5;
  localparam logic [3:0] FUNC_SLL  = 4'd6;
  localparam logic [3:0] FUNC_SRL  = 4'd7;
  localparam logic [3:0] FUNC_JALR = 4'd8;
  localparam logic [3:0] FUNC_BEQ  = 4'd9;
  localparam logic [3:0] FUNC_BNE  = 4'd10;
  localparam logic [3:0] FUNC_BLT  = 4'd11;
  localparam logic [3:0] FUNC_BGE  = 4'd12;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        bcond_q, bcond_d;
`ifndef FAST_SHIFT_EN
  logic [4:0]  cnt_q, cnt_d;
`endif

  logic [31:0] sum, diff, exec_result;
  logic        exec_bcond;

  always_comb begin
    sum         = a_q + b_q;
    diff        = a_q - b_q;
    exec_result = '0;
    exec_bcond  = 1'b0;
    case (op_q)
      FUNC_ADD:  exec_result = sum;
      FUNC_SUB:  exec_result = diff;
      FUNC_AND:  exec_result = a_q & b_q;
      FUNC_OR:   exec_result = a_q | b_q;
      FUNC_XOR:  exec_result = a_q ^ b_q;
      FUNC_JALR: exec_result = {sum[31:1], 1'b0};
      FUNC_BEQ: begin exec_result = diff; exec_bcond = (a_q == b_q); end
      FUNC_BNE: begin exec_result = diff; exec_bcond = (a_q != b_q); end
      FUNC_BLT: begin exec_result = diff; exec_bcond = ($signed(a_q) <  $signed(b_q)); end
      FUNC_BGE: begin exec_result = diff; exec_bcond = ($signed(a_q) >= $signed(b_q)); end
`ifdef FAST_SHIFT_EN
      FUNC_SLL:  exec_result = a_q << b_q[4:0];
      FUNC_SRL:  exec_result = a_q >> b_q[4:0];
`else
      // Only zero-amount shifts reach EXEC in iterative mode.
      FUNC_SLL,
      FUNC_SRL:  exec_result = a_q;
`endif
      default:   exec_result = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    bcond_d  = bcond_q;
`ifndef FAST_SHIFT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.alu_op;
          a_d     = bus.alu_in_1;
          b_d     = bus.alu_in_2;
          state_d = EXEC;
`ifndef FAST_SHIFT_EN
          cnt_d   = bus.alu_in_2[4:0];
          if ((bus.alu_op == FUNC_SLL || bus.alu_op == FUNC_SRL) && bus.alu_in_2[4:0] != 5'd0)
            state_d = SHIFT;
`endif
        end
      end
      EXEC: begin
        state_d  = DONE;
        result_d = exec_result;
        bcond_d  = exec_bcond;
      end
`ifndef FAST_SHIFT_EN
      // One extra SHIFT cycle after the count drains gives done at shamt+2.
      SHIFT: begin
        if (cnt_q == 5'd0) begin
          state_d  = DONE;
          result_d = a_q;
          bcond_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 5'd1;
          a_d   = (op_q == FUNC_SLL) ? (a_q << 1) : (a_q >> 1);
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      bcond_q  <= 1'b0;
`ifndef FAST_SHIFT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      bcond_q  <= bcond_d;
`ifndef FAST_SHIFT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    bus.busy       = (state_q != IDLE);
    bus.done       = (state_q == DONE);
    bus.alu_result = result_q;
    bus.alu_bcond  = bcond_q;
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu; shift latency expectations
// follow FAST_SHIFT_EN when the bench is built with that macro.
module tb_multicycle_alu;
  localparam logic [3:0] FUNC_ADD  = 4'd1;
  localparam logic [3:0] FUNC_SUB  = 4'd2;
  localparam logic [3:0] FUNC_AND  = 4'd3;
  localparam logic [3:0] FUNC_OR   = 4'd4;
  localparam logic [3:0] FUNC_XOR  = 4'd5;
  localparam logic [3:0] FUNC_SLL  = 4'd6;
  localparam logic [3:0] FUNC_SRL  = 4'd7;
  localparam logic [3:0] FUNC_JALR = 4'd8;
  localparam logic [3:0] FUNC_BEQ  = 4'd9;
  localparam logic [3:0] FUNC_BNE  = 4'd10;
  localparam logic [3:0] FUNC_BLT  = 4'd11;
  localparam logic [3:0] FUNC_BGE  = 4'd12;
`ifdef FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_if bus ();
  multicycle_alu dut (.clk(clk), .reset(reset), .bus(bus));

  // Issue one start in IDLE, scramble inputs afterwards, wait for done (bounded).
  // Returns one cycle after done, i.e. in the following IDLE cycle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at, output int lat, output logic [31:0] res,
                        output logic bc, output int busy_cnt, output logic busy_after);
    lat = -1; res = '0; bc = 1'b0; busy_cnt = 0;
    bus.start = 1'b1; bus.alu_op = op; bus.alu_in_1 = a; bus.alu_in_2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.alu_op = FUNC_OR; bus.alu_in_1 = '1; bus.alu_in_2 = 32'h1f;
    for (int k = 1; k <= 60; k++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = k; res = bus.alu_result; bc = bus.alu_bcond;
        break;
      end
      if (k == pulse_at) begin bus.start = 1'b1; bus.alu_op = FUNC_ADD; end
      else bus.start = 1'b0;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    busy_after = bus.busy;
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.start = 1'b1; bus.alu_op = FUNC_ADD;
    bus.alu_in_1 = 32'd1; bus.alu_in_2 = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.alu_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.alu_result); end
    checks++; if (bus.alu_bcond !== 1'b0) begin failures++; $display("FAIL reset_bcond got=%b exp=0", bus.alu_bcond); end
    reset = 1'b0;
  endtask

  // Called immediately after reset release: also proves the first edge accepts start.
  task automatic test_add;
    int lat, bcnt; logic [31:0] res; logic bc, ba;
    run_op(FUNC_ADD, 32'hFFFF_FFFF, 32'h1, 0, lat, res, bc, bcnt, ba);
    checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++; if (res !== 32'h0) begin failures++; $display("FAIL add_result got=%h exp=00000000", res); end
    checks++; if (bc !== 1'b0) begin failures++; $display("FAIL add_bcond got=%b exp=0", bc); end
    checks++; if (bcnt !== 2) begin failures++; $display("FAIL add_busy_cycles got=%0d exp=2", bcnt); end
    checks++; if (ba !== 1'b0) begin failures++; $display("FAIL add_busy_after got=%b exp=0", ba); end
  endtask

  task automatic test_arith_logic;
    logic [3:0]  ops  [7] = '{FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_JALR, 4'd0, 4'd15};
    logic [31:0] av   [7] = '{32'd5, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'h1001, 32'd3, 32'd9};
    logic [31:0] bv   [7] = '{32'd7, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h2, 32'd4, 32'd9};
    logic [31:0] expr [7] = '{32'hFFFF_FFFE, 32'h00F0_1200, 32'hFFF0_FF34, 32'hFF00_ED34, 32'h1002, 32'h0, 32'h0};
    int lat, bcnt; logic [31:0] res; logic bc, ba;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], av[i], bv[i], 0, lat, res, bc, bcnt, ba);
      checks++; if (lat !== 2) begin failures++; $display("FAIL alu_latency[%0d] got=%0d exp=2", i, lat); end
      checks++; if (res !== expr[i]) begin failures++; $display("FAIL alu_result[%0d] got=%h exp=%h", i, res, expr[i]); end
      checks++; if (bc !== 1'b0) begin failures++; $display("FAIL alu_bcond[%0d] got=%b exp=0", i, bc); end
    end
  endtask

  task automatic test_branch;
    logic [3:0]  ops  [5] = '{FUNC_BLT, FUNC_BGE, FUNC_BNE, FUNC_BEQ, FUNC_BLT};
    logic [31:0] av   [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd5, 32'd5, 32'd1};
    logic [31:0] bv   [5] = '{32'h1, 32'h1, 32'd5, 32'd5, 32'hFFFF_FFFE};
    logic [31:0] expr [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h0, 32'h0, 32'h3};
    logic        expb [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat, bcnt; logic [31:0] res; logic bc, ba;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], av[i], bv[i], 0, lat, res, bc, bcnt, ba);
      checks++; if (lat !== 2) begin failures++; $display("FAIL br_latency[%0d] got=%0d exp=2", i, lat); end
      checks++; if (res !== expr[i]) begin failures++; $display("FAIL br_result[%0d] got=%h exp=%h", i, res, expr[i]); end
      checks++; if (bc !== expb[i]) begin failures++; $display("FAIL br_bcond[%0d] got=%b exp=%b", i, bc, expb[i]); end
    end
  endtask

  task automatic test_shift;
    logic [3:0]  ops  [4] = '{FUNC_SRL, FUNC_SRL, FUNC_SLL, FUNC_SRL};
    logic [31:0] av   [4] = '{32'h8000_0000, 32'h8000_0000, 32'h3, 32'hF0};
    logic [31:0] bv   [4] = '{32'h0, 32'h4, 32'h1, 32'h24};
    logic [31:0] expr [4] = '{32'h8000_0000, 32'h0800_0000, 32'h6, 32'hF};
    int          expl [4] = '{2, 6, 3, 6};
    int lat, bcnt, el; logic [31:0] res; logic bc, ba; logic seen;
    for (int i = 0; i < 4; i++) begin
      el = FAST ? 2 : expl[i];
      run_op(ops[i], av[i], bv[i], 0, lat, res, bc, bcnt, ba);
      checks++; if (lat !== el) begin failures++; $display("FAIL sh_latency[%0d] got=%0d exp=%0d", i, lat, el); end
      checks++; if (res !== expr[i]) begin failures++; $display("FAIL sh_result[%0d] got=%h exp=%h", i, res, expr[i]); end
    end
    // SLL by 31 with a stray start at start+5 that must be ignored.
    el = FAST ? 2 : 33;
    run_op(FUNC_SLL, 32'h1, 32'd31, 5, lat, res, bc, bcnt, ba);
    checks++; if (lat !== el) begin failures++; $display("FAIL sll31_latency got=%0d exp=%0d", lat, el); end
    checks++; if (res !== 32'h8000_0000) begin failures++; $display("FAIL sll31_result got=%h exp=80000000", res); end
    checks++; if (bcnt !== el) begin failures++; $display("FAIL sll31_busy_cycles got=%0d exp=%0d", bcnt, el); end
    seen = ba;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.busy || bus.done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL sll31_stray_start got=%b exp=0", seen); end
    checks++; if (bus.alu_result !== 32'h8000_0000) begin failures++; $display("FAIL sll31_hold got=%h exp=80000000", bus.alu_result); end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt; logic [31:0] res; logic bc, ba;
    run_op(FUNC_ADD, 32'd1, 32'd2, 0, lat, res, bc, bcnt, ba);
    checks++; if (res !== 32'd3) begin failures++; $display("FAIL b2b_first got=%h exp=00000003", res); end
    checks++; if (ba !== 1'b0) begin failures++; $display("FAIL b2b_gap_busy got=%b exp=0", ba); end
    run_op(FUNC_SUB, 32'd10, 32'd3, 0, lat, res, bc, bcnt, ba);
    checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
    checks++; if (res !== 32'd7) begin failures++; $display("FAIL b2b_second got=%h exp=00000007", res); end
  endtask

  task automatic test_reset_abort;
    int lat, bcnt, rst_k; logic [31:0] res; logic bc, ba; logic seen;
    run_op(FUNC_BLT, 32'hFFFF_FFFE, 32'h1, 0, lat, res, bc, bcnt, ba);
    checks++; if (bus.alu_bcond !== 1'b1) begin failures++; $display("FAIL abort_pre_bcond got=%b exp=1", bus.alu_bcond); end
    rst_k = FAST ? 1 : 4;
    seen = 1'b0;
    bus.start = 1'b1; bus.alu_op = FUNC_SRL; bus.alu_in_1 = 32'hFFFF_0000; bus.alu_in_2 = 32'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k < rst_k; k++) begin
      if (bus.done) seen = 1'b1;
      @(posedge clk); #1;
    end
    if (bus.done) seen = 1'b1;
    // Reset with a simultaneous start: the start must not be accepted.
    reset = 1'b1; bus.start = 1'b1; bus.alu_op = FUNC_ADD; bus.alu_in_1 = 32'd3; bus.alu_in_2 = 32'd4;
    @(posedge clk); #1;
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_early_done got=%b exp=0", seen); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", bus.done); end
    checks++; if (bus.alu_result !== 32'h0) begin failures++; $display("FAIL abort_result got=%h exp=0", bus.alu_result); end
    checks++; if (bus.alu_bcond !== 1'b0) begin failures++; $display("FAIL abort_bcond got=%b exp=0", bus.alu_bcond); end
    reset = 1'b0;
    run_op(FUNC_ADD, 32'd3, 32'd4, 0, lat, res, bc, bcnt, ba);
    checks++; if (lat !== 2) begin failures++; $display("FAIL abort_restart_latency got=%0d exp=2", lat); end
    checks++; if (res !== 32'd7) begin failures++; $display("FAIL abort_restart_result got=%h exp=00000007", res); end
  endtask

  initial begin
    bus.start = 1'b0; bus.alu_op = '0; bus.alu_in_1 = '0; bus.alu_in_2 = '0;
    test_reset;
    test_add;
    test_arith_logic;
    test_branch;
    test_shift;
    test_back_to_back;
    test_reset_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation, sampled at rising clk.
REQ-005 The block SHALL have port alu_op, input, 4 bits: operation code, using the FUNC_* encodings defined in alu_func.v.
REQ-006 The block SHALL have port alu_in_1, input, 32 bits: operand A.
REQ-007 The block SHALL have port alu_in_2, input, 32 bits: operand B; bits [4:0] are the shift amount for shifts.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an accepted operation is in flight.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port alu_result, output, 32 bits: registered result.
REQ-011 The block SHALL have port alu_bcond, output, 1 bit: registered branch condition.

Function
REQ-012 The FSM SHALL have states IDLE, EXEC, SHIFT and DONE.
REQ-013 start SHALL be accepted only in IDLE; on acceptance, alu_op, alu_in_1 and alu_in_2 SHALL be latched, and later operand changes SHALL have no effect.
REQ-014 start asserted in any state other than IDLE SHALL be ignored: no queuing and no error.
REQ-015 Accepted start with a non-shift op SHALL go IDLE -> EXEC -> DONE -> IDLE, with done high exactly 2 cycles after the start edge.
REQ-016 FUNC_ADD: result SHALL be A+B, modulo 2^32. FUNC_SUB: result SHALL be A-B, modulo 2^32.
REQ-017 FUNC_AND, FUNC_OR and FUNC_XOR: result SHALL be the bitwise AND, OR and XOR of A and B respectively.
REQ-018 FUNC_JALR: result SHALL be (A+B) with bit 0 cleared.
REQ-019 FUNC_BEQ, FUNC_BNE, FUNC_BLT and FUNC_BGE: alu_bcond SHALL be A==B, A!=B, signed A<B and signed A>=B respectively, and result SHALL be A-B.
REQ-020 For all non-branch ops, alu_bcond SHALL be 0.
REQ-021 An undefined alu_op, including 0, SHALL produce result 0 and bcond 0 with non-shift timing.
REQ-022 FUNC_SLL and FUNC_SRL (iterative mode): IDLE -> SHIFT, shifting by 1 bit per cycle for shamt = B[4:0] cycles, then -> DONE.
REQ-023 SRL SHALL be a logical shift with zero fill.
REQ-024 shamt = 0 SHALL skip SHIFT (IDLE -> EXEC -> DONE) and return A unchanged.
REQ-025 shamt = 31 SHALL assert done 33 cycles after start; shamt = n > 0 SHALL assert done n+2 cycles after start.
REQ-026 busy SHALL be high from the cycle after acceptance through the DONE cycle inclusive, and low in IDLE.
REQ-027 alu_result and alu_bcond SHALL update only at entry to DONE, and SHALL hold their values until the next DONE or reset.
REQ-028 start may be asserted in the cycle after DONE (IDLE), giving back-to-back operations with a 1-cycle gap.

Reset
REQ-029 When reset is high at a rising clk, the FSM SHALL go to IDLE, and busy, done, alu_result and alu_bcond SHALL be 0.
REQ-030 Reset asserted during EXEC or SHIFT SHALL abort the operation with no done pulse, and start SHALL be ignored while reset is high.
REQ-031 The first start SHALL be accepted on the first rising clk with reset low.

Configuration
REQ-032 The macro SHALL be FAST_SHIFT_EN.
REQ-033 When FAST_SHIFT_EN is defined, SLL and SRL SHALL use a combinational barrel shifter, the SHIFT state SHALL be unused, and shifts SHALL follow non-shift timing (done 2 cycles after start).
REQ-034 When FAST_SHIFT_EN is undefined, REQ-022 to REQ-025 SHALL apply.
REQ-035 Results SHALL be identical in both modes.

Verification
REQ-036 ADD with A=0xFFFFFFFF, B=1 -> done at start+2, alu_result=0x00000000, alu_bcond=0, busy high for 2 cycles.
REQ-037 BLT with A=0xFFFFFFFE, B=1 -> alu_bcond=1; BGE with the same operands -> alu_bcond=0; BNE with A=B=5 -> alu_bcond=0.
REQ-038 Iterative SLL with A=0x1, B=31 -> done at start+33, alu_result=0x80000000; a start pulse at start+5 is ignored.
REQ-039 SRL with A=0x80000000, B=0 -> done at start+2, alu_result=0x80000000; JALR with A=0x1001, B=0x2 -> alu_result=0x1002.
REQ-040 SRL with B=10 and reset asserted at start+4 -> no done pulse, all outputs 0 the next cycle, and a new ADD start is accepted after reset deasserts.
REQ-041 The bench SHALL rerun REQ-038 with FAST_SHIFT_EN defined -> done at start+2, same result.
